// File: rtl/fp_test_sequencer.sv
// fp_test_sequencer: switch-driven operand/control loader for an FP unit.
// Each step pulse loads one IN_W-bit switch chunk into the operand bank and
// then latches a control word. The sequencer then pulses start, waits for
// the DUT result (with a cycle timeout) and pages the captured result onto
// the display. restart returns to loading from SHOW or ERR.
module fp_test_sequencer #(
  parameter int unsigned IN_W    = 16,
  parameter int unsigned OP_W    = 32,
  parameter int unsigned N_OPS   = 2,
  parameter int unsigned CTRL_W  = 5,
  parameter int unsigned RES_W   = 32,
  parameter int unsigned FLAG_W  = 5,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic                  restart,
  input  logic [IN_W-1:0]       sw,
  output logic [N_OPS*OP_W-1:0] operands,
  output logic [CTRL_W-1:0]     ctrl,
  output logic                  start,
  input  logic                  dut_valid,
  input  logic [RES_W-1:0]      dut_result,
  input  logic [FLAG_W-1:0]     dut_flags,
  output logic [IN_W-1:0]       disp_data,
  output logic                  disp_en,
  output logic [FLAG_W-1:0]     flags_out,
  output logic [2:0]            phase,
  output logic                  timeout_err
);

  localparam int unsigned CHUNKS = OP_W / IN_W;
  localparam int unsigned PAGES  = RES_W / IN_W;
  localparam int unsigned CH_W   = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int unsigned OI_W   = (N_OPS > 1) ? $clog2(N_OPS) : 1;
  localparam int unsigned PG_W   = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned CNT_W  = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_CTRL  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_SHOW  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e                  state_q;
  logic [N_OPS*OP_W-1:0]   operands_q;
  logic [CTRL_W-1:0]       ctrl_q;
  logic                    start_q;
  logic [CH_W-1:0]         chunk_q;
  logic [OI_W-1:0]         op_q;
  logic [PG_W-1:0]         page_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [RES_W-1:0]        result_q;
  logic [FLAG_W-1:0]       flags_q;
  logic [IN_W-1:0]         disp_data_q;
  logic                    disp_en_q;
  logic [FLAG_W-1:0]       flags_out_q;
  logic                    timeout_err_q;
  logic [IN_W-1:0]         page_sel;

  // Select the result chunk addressed by the current display page.
  always_comb begin
    page_sel = '0;
    for (int unsigned p = 0; p < PAGES; p++) begin
      if (page_q == PG_W'(p)) page_sel = result_q[p*IN_W +: IN_W];
    end
  end

  // Sequencer FSM with registered operand, control, start and display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_LOAD;
      operands_q    <= '0;
      ctrl_q        <= '0;
      start_q       <= 1'b0;
      chunk_q       <= '0;
      op_q          <= '0;
      page_q        <= '0;
      cnt_q         <= '0;
      result_q      <= '0;
      flags_q       <= '0;
      disp_data_q   <= '0;
      disp_en_q     <= 1'b0;
      flags_out_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // Display outputs trail the state/page by one cycle.
      start_q     <= 1'b0;
      disp_en_q   <= (state_q == S_SHOW);
      disp_data_q <= page_sel;
      flags_out_q <= flags_q;

      case (state_q)
        S_LOAD: begin
          if (step) begin
            for (int unsigned k = 0; k < N_OPS; k++) begin
              for (int unsigned c = 0; c < CHUNKS; c++) begin
                if (op_q == OI_W'(k) && chunk_q == CH_W'(c))
                  operands_q[(k*CHUNKS + c)*IN_W +: IN_W] <= sw;
              end
            end
            if (chunk_q == CH_W'(CHUNKS - 1)) begin
              chunk_q <= '0;
              if (op_q == OI_W'(N_OPS - 1)) begin
                op_q    <= '0;
                state_q <= S_CTRL;
              end else begin
                op_q <= op_q + OI_W'(1);
              end
            end else begin
              chunk_q <= chunk_q + CH_W'(1);
            end
          end
        end

        S_CTRL: begin
          if (step) begin
            ctrl_q        <= sw[CTRL_W-1:0];
            start_q       <= 1'b1;
            // Cleared on entry so timeout_err already reads 0 while start is high.
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            state_q       <= S_START;
          end
        end

        S_START: begin
          cnt_q         <= '0;
          timeout_err_q <= 1'b0;
          state_q       <= S_WAIT;
        end

        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (dut_valid) begin
            result_q <= dut_result;
            flags_q  <= dut_flags;
            page_q   <= '0;
            state_q  <= S_SHOW;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            state_q       <= S_ERR;
          end
        end

        S_SHOW: begin
          if (restart) begin
            chunk_q <= '0;
            op_q    <= '0;
            state_q <= S_LOAD;
          end else if (step) begin
            if (page_q == PG_W'(PAGES - 1)) page_q <= '0;
            else                            page_q <= page_q + PG_W'(1);
          end
        end

        S_ERR: begin
          timeout_err_q <= 1'b1;
          if (restart) begin
            chunk_q <= '0;
            op_q    <= '0;
            state_q <= S_LOAD;
          end
        end

        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign operands    = operands_q;
  assign ctrl        = ctrl_q;
  assign start       = start_q;
  assign disp_data   = disp_data_q;
  assign disp_en     = disp_en_q;
  assign flags_out   = flags_out_q;
  assign phase       = state_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_fp_test_sequencer.sv
// Directed bench for fp_test_sequencer (16-bit chunks, two 32-bit operands,
// TIMEOUT reduced to 8 so the timeout path is reachable quickly).
module tb_fp_test_sequencer;

  logic        clk;
  logic        rst_n;
  logic        step;
  logic        restart;
  logic [15:0] sw;
  logic [63:0] operands;
  logic [4:0]  ctrl;
  logic        start;
  logic        dut_valid;
  logic [31:0] dut_result;
  logic [4:0]  dut_flags;
  logic [15:0] disp_data;
  logic        disp_en;
  logic [4:0]  flags_out;
  logic [2:0]  phase;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  fp_test_sequencer #(
    .IN_W   (16),
    .OP_W   (32),
    .N_OPS  (2),
    .CTRL_W (5),
    .RES_W  (32),
    .FLAG_W (5),
    .TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .restart    (restart),
    .sw         (sw),
    .operands   (operands),
    .ctrl       (ctrl),
    .start      (start),
    .dut_valid  (dut_valid),
    .dut_result (dut_result),
    .dut_flags  (dut_flags),
    .disp_data  (disp_data),
    .disp_en    (disp_en),
    .flags_out  (flags_out),
    .phase      (phase),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_step(input logic [15:0] v);
    sw   = v;
    step = 1'b1;
    cyc();
    step = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; step = 1'b0; restart = 1'b0; sw = '0;
    dut_valid = 1'b0; dut_result = '0; dut_flags = '0;
    cyc(); cyc();
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_operands", operands, 64'd0);
    chk("rst_ctrl", 64'(ctrl), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_disp_en", 64'(disp_en), 64'd0);
    chk("rst_disp_data", 64'(disp_data), 64'd0);
    chk("rst_flags", 64'(flags_out), 64'd0);
    chk("rst_tmo", 64'(timeout_err), 64'd0);
    rst_n = 1'b1;
    cyc();
    chk("idle_hold", 64'(phase), 64'd0);

    // 1: load 1.0 and 2.0, ctrl 0x08
    do_step(16'h0000);
    chk("t1_phase_load", 64'(phase), 64'd0);
    do_step(16'h3F80);
    do_step(16'h0000);
    do_step(16'h4000);
    chk("t1_phase_ctrl", 64'(phase), 64'd1);
    chk("t1_operands", operands, 64'h40000000_3F800000);
    chk("t1_start_lo", 64'(start), 64'd0);
    do_step(16'h0008);
    chk("t1_start_hi", 64'(start), 64'd1);
    chk("t1_phase_start", 64'(phase), 64'd2);
    chk("t1_ctrl", 64'(ctrl), 64'h08);
    cyc();
    chk("t1_start_drop", 64'(start), 64'd0);
    chk("t1_phase_wait", 64'(phase), 64'd3);

    // 2: result after a few WAIT cycles, paged display with wrap
    cyc(); cyc();
    dut_valid = 1'b1; dut_result = 32'h40400000; dut_flags = 5'h00;
    cyc();
    dut_valid = 1'b0;
    chk("t2_phase_show", 64'(phase), 64'd4);
    chk("t2_disp_en_lag", 64'(disp_en), 64'd0);
    cyc();
    chk("t2_disp_en", 64'(disp_en), 64'd1);
    chk("t2_page0", 64'(disp_data), 64'h0000);
    chk("t2_flags", 64'(flags_out), 64'h00);
    do_step(16'h0000);
    cyc();
    chk("t2_page1", 64'(disp_data), 64'h4040);
    do_step(16'h0000);
    cyc();
    chk("t2_page_wrap", 64'(disp_data), 64'h0000);

    // 3: timeout after 8 WAIT cycles
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("t3_restart_phase", 64'(phase), 64'd0);
    do_step(16'h0001); do_step(16'h0002); do_step(16'h0003); do_step(16'h0004);
    do_step(16'h0003);
    chk("t3_start", 64'(start), 64'd1);
    cyc();
    repeat (7) cyc();
    chk("t3_wait_7", 64'(phase), 64'd3);
    chk("t3_tmo_lo", 64'(timeout_err), 64'd0);
    cyc();
    chk("t3_phase_err", 64'(phase), 64'd5);
    chk("t3_tmo_hi", 64'(timeout_err), 64'd1);
    cyc();
    chk("t3_disp_en", 64'(disp_en), 64'd0);
    do_step(16'h0000);
    chk("t3_err_step", 64'(phase), 64'd5);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("t3_err_restart", 64'(phase), 64'd0);
    chk("t3_tmo_sticky", 64'(timeout_err), 64'd1);

    // 4: stray valid during LOAD is ignored
    dut_valid = 1'b1; dut_result = 32'hDEADBEEF; dut_flags = 5'h1F;
    cyc();
    dut_valid = 1'b0;
    cyc();
    chk("t4_stray_data", 64'(disp_data), 64'h0000);
    chk("t4_stray_flags", 64'(flags_out), 64'h00);
    do_step(16'h1111); do_step(16'h2222); do_step(16'h3333); do_step(16'h4444);
    chk("t4_operands", operands, 64'h44443333_22221111);
    do_step(16'h0015);
    chk("t4_start", 64'(start), 64'd1);
    chk("t4_tmo_cleared", 64'(timeout_err), 64'd0);
    chk("t4_ctrl", 64'(ctrl), 64'h15);
    cyc();
    dut_valid = 1'b1; dut_result = 32'h12345678; dut_flags = 5'h15;
    cyc();
    dut_valid = 1'b0;
    chk("t4_phase_show", 64'(phase), 64'd4);
    cyc();
    chk("t4_page0", 64'(disp_data), 64'h5678);
    chk("t4_flags", 64'(flags_out), 64'h15);
    do_step(16'h0000);
    cyc();
    chk("t4_page1", 64'(disp_data), 64'h1234);

    // 5: restart and step together
    restart = 1'b1; step = 1'b1; sw = 16'hAAAA;
    cyc();
    restart = 1'b0; step = 1'b0;
    chk("t5_phase", 64'(phase), 64'd0);
    chk("t5_operands_kept", operands, 64'h44443333_22221111);
    cyc();
    chk("t5_page_kept", 64'(disp_data), 64'h1234);
    chk("t5_disp_off", 64'(disp_en), 64'd0);
    do_step(16'hAAAA);
    chk("t5_first_chunk", operands, 64'h44443333_2222AAAA);

    // 6: reset mid-WAIT, late valid ignored
    do_step(16'h0002); do_step(16'h0003); do_step(16'h0004);
    chk("t6_operands", operands, 64'h00040003_0002AAAA);
    do_step(16'h0001);
    cyc();
    cyc();
    chk("t6_in_wait", 64'(phase), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_phase", 64'(phase), 64'd0);
    chk("t6_rst_start", 64'(start), 64'd0);
    chk("t6_rst_operands", operands, 64'd0);
    chk("t6_rst_ctrl", 64'(ctrl), 64'd0);
    chk("t6_rst_disp", 64'(disp_data), 64'd0);
    chk("t6_rst_tmo", 64'(timeout_err), 64'd0);
    cyc();
    rst_n = 1'b1;
    dut_valid = 1'b1; dut_result = 32'hCAFEF00D; dut_flags = 5'h1F;
    cyc(); cyc();
    dut_valid = 1'b0;
    cyc();
    chk("t6_late_phase", 64'(phase), 64'd0);
    chk("t6_late_disp", 64'(disp_data), 64'd0);
    chk("t6_late_flags", 64'(flags_out), 64'd0);
    chk("t6_late_en", 64'(disp_en), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_test_sequencer.md
Name: fp_test_sequencer

Overview:
- Parametrised successor to the board-level operand loader that drives the FP unit from the switches.
- Operand width, switch width, operand count and control width are all parameters.
- Loading advances on an explicit debounced step pulse rather than on every clock.
- Adds a result wait timeout, multi-page result display with wrap-around, and a restart path.
- Sits between the switch/button inputs and the DUT (fp_adder or successors) and feeds the hex display.

Parameters:
- IN_W, 16, switch/display chunk width in bits.
- OP_W, 32, operand width; must be a multiple of IN_W.
- N_OPS, 2, number of operands loaded; 1..4.
- CTRL_W, 5, control word width (op_code, mode, round bits); CTRL_W <= IN_W.
- RES_W, 32, DUT result width; must be a multiple of IN_W.
- FLAG_W, 5, DUT flag width.
- TIMEOUT, 1024, maximum number of WAIT cycles before error; must be >= 2.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- step, in, 1, single-cycle advance pulse (already debounced/synchronised).
- restart, in, 1, single-cycle pulse: return to load from SHOW/ERR.
- sw, in, IN_W, switch data.
- operands, out, N_OPS*OP_W, operand k at bits [k*OP_W +: OP_W].
- ctrl, out, CTRL_W, latched control word.
- start, out, 1, one-cycle DUT start pulse.
- dut_valid, in, 1, DUT result valid.
- dut_result, in, RES_W, DUT result.
- dut_flags, in, FLAG_W, DUT flags.
- disp_data, out, IN_W, currently selected result page.
- disp_en, out, 1, display enable.
- flags_out, out, FLAG_W, captured flags.
- phase, out, 3, state code: LOAD=0, CTRL=1, START=2, WAIT=3, SHOW=4, ERR=5.
- timeout_err, out, 1, sticky timeout indicator.

Behaviour:
- Reset values (asynchronous on rst_n low), all outputs:
  - phase = LOAD.
  - operands, ctrl, start, disp_data, flags_out = 0; disp_en = 0; timeout_err = 0.
  - All counters 0. Internal result register = 0.
- Derived constants: CHUNKS = OP_W/IN_W; PAGES = RES_W/IN_W.
- LOAD:
  - On step: write sw into operand op_idx at chunk chunk_idx. Chunk 0 is the least significant.
  - chunk_idx increments. When chunk_idx = CHUNKS-1 it wraps to 0 and op_idx increments.
  - The step that writes the last chunk of operand N_OPS-1 moves to CTRL at the next edge.
  - Without step, state and data hold.
- CTRL:
  - On step: ctrl <= sw[CTRL_W-1:0]; move to START.
- START:
  - Lasts exactly one cycle; start = 1 only here (registered, high the cycle after the CTRL step).
  - WAIT counter cleared; timeout_err cleared; next state WAIT.
- WAIT:
  - Counter increments each cycle.
  - If dut_valid: capture dut_result and dut_flags, set page = 0, go to SHOW.
  - Else if counter = TIMEOUT-1: set timeout_err, go to ERR.
  - dut_valid in the same cycle as the counter expiry: valid wins.
- SHOW:
  - disp_en = 1; disp_data = result[page*IN_W +: IN_W]; flags_out = captured flags.
  - On step: page increments and wraps from PAGES-1 to 0.
- ERR:
  - disp_en = 0; timeout_err = 1; step is ignored.
- restart:
  - In SHOW or ERR: go to LOAD with op_idx = chunk_idx = 0. Operands and ctrl are retained until overwritten.
  - timeout_err stays set until the next START.
  - restart and step in the same cycle: restart wins, and step has no effect.
  - restart in any other state is ignored.
- dut_valid outside WAIT is ignored; the captured result is unchanged.
- step during START or WAIT is ignored.
- rst_n low at any point, including mid-WAIT: immediate return to reset values, and any in-flight start is dropped.
- Output timing: disp_data, disp_en and flags_out are registered and change one cycle after the state/page change.
- Timing reference for the Test Plan: TIMEOUT counts cycles spent in WAIT, with the first WAIT cycle counted as 0.

Test Plan:
1. Defaults (IN_W=16, OP_W=32, N_OPS=2). Steps with sw = 0x0000, 0x3F80, 0x0000, 0x4000, then CTRL step with sw = 0x0008.
   -> operands = {0x40000000, 0x3F800000}, ctrl = 0x08.
   -> start high for exactly one cycle, one cycle after the CTRL step; phase then = 3.
2. After 1: DUT raises dut_valid 3 cycles into WAIT with result 0x40400000, flags 0x00.
   -> phase = 4, disp_en = 1, disp_data = 0x0000.
   -> step gives 0x4040; a further step wraps to 0x0000.
3. TIMEOUT=8, no dut_valid.
   -> phase = 5 and timeout_err = 1 after the 8th WAIT cycle, disp_en = 0.
   -> A subsequent restart gives phase = 0 with timeout_err still 1.
   -> After reloading and reaching START, timeout_err = 0.
4. dut_valid pulsed with result 0xDEADBEEF during LOAD, then a normal run returns 0x12345678.
   -> SHOW pages read 0x5678 then 0x1234; 0xDEADBEEF never appears.
5. In SHOW, restart and step together.
   -> phase = 0, page unchanged; the next step with sw = 0xAAAA writes only operand 0 bits [15:0].
6. rst_n driven low 2 cycles into WAIT.
   -> All outputs return to reset values immediately (phase 0, start 0, operands 0).
   -> Late dut_valid after reset release is ignored.
